hex_display_ctrl: RTL
=====================

// Module: hex_display_ctrl
// PURPOSE
//  Takes a signed 32-bit result from the Nios/Qsys calculator datapath and drives all eight DE2-115
//  HEX displays. Converts the value to BCD sequentially (shift-and-add-3) and blanks leading zeros.
//  Places a minus sign in front of negative values and shows "Err" for values that do not fit.
//  The segment patterns it drives use the same encoding as the single-digit 7-seg decoder.
// PARAMETERS
//  DIGITS     8   number of 7-seg digits driven (digit 0 = rightmost)
//  CONV_BITS  27  magnitude bits converted; must satisfy 2**CONV_BITS > 10**DIGITS - 1
// PORTS
//  clk1      in   1          single system clock; every register is on posedge clk1
//  reset_n   in   1          synchronous, active-low reset
//  load      in   1          one-cycle request: capture value and start a conversion
//  value     in   32         two's-complement number to display; sampled only when load is accepted
//  busy      out  1          high from the accept edge until done; load is ignored while high
//  done      out  1          one-cycle pulse on the edge where hex_seg updates
//  overflow  out  1          1 = the last accepted value is not displayable; held until the next accept
//  hex_seg   out  7*DIGITS   active-low segments {g..a}; digit i at [7*i+6:7*i]
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, overflow=0, every digit 7'h7F (all off).
//   Reset mid-conversion abandons the conversion; no done pulse follows.
//  FSM: IDLE -> CONV -> FMT -> IDLE.
//   IDLE: load=1 at edge k -> capture sign, mag=|value| (32-bit), clear BCD, busy=1, go CONV.
//   CONV: CONV_BITS cycles (edges k+1..k+CONV_BITS); 5-bit iteration counter.
//    Each step: every BCD nibble >=5 gets +3, then {bcd,mag} shifts left by 1 (MSB of mag first).
//   FMT: one edge (k+CONV_BITS+1): hex_seg and overflow register, done=1 for one cycle,
//    busy=0, go IDLE. Total latency = CONV_BITS+1 edges after the accept edge (default 28).
//   load while busy=1: ignored, no queuing. load on the same edge busy falls: also ignored
//    (accept only when state is IDLE at that edge).
//   hex_seg keeps the previous frame throughout CONV; no intermediate values are shown.
//  Range and overflow (checked on the captured magnitude, 32-bit unsigned compare):
//   non-negative: mag <= 10**DIGITS-1 (99_999_999); negative: mag <= 10**(DIGITS-1)-1 (9_999_999).
//   value = -2**31 is overflow. Overflow: digits 2..0 = "E","r","r", the other digits blank.
//   The conversion still runs its full length so latency is constant.
//  Formatting (not overflow):
//   Leading-zero blanking: digits above the most significant nonzero nibble are off.
//   value 0 -> digit 0 = "0", the rest blank.
//   Negative: the minus sign (segment g only) goes in the digit directly left of the MS nonzero digit.
//  Segment codes (active-low, {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 blank=1111111 minus=0111111
//   E=0000110 r=0101111.
//  BCD nibbles never exceed 9 after a step; the encoder maps any nibble >9 to blank
//   (no case holds its old value).
// STRUCTURE
//  Package hex_display_pkg: SEG_* localparams for the 14 codes above, state encoding
//   (IDLE/CONV/FMT), MAX_POS/MAX_NEG limits, and a function seg_encode(nibble) -> 7-bit.
//  Sub-module bin2bcd_step: combinational add-3-then-shift over DIGITS nibbles.
//   Ports: bcd_in, msb_in, bcd_out. The controller instantiates it once and owns every register.
//  Top level: FSM, iteration counter, sign/overflow flags, blanking/sign placement, output registers.
// TESTING
//  1 reset: hold reset_n=0 for 3 edges mid-conversion -> busy=0, done never pulses, hex_seg all 7'h7F.
//  2 load value=12345 -> done exactly 28 edges after accept; digits4..0 = 1,2,3,4,5;
//    digits7..5 blank; overflow=0.
//  3 load value=0 -> digit0=1000000, others 1111111;
//    then load value=-7 -> digit1=0111111, digit0=1111000, others blank.
//  4 boundaries: 99_999_999 -> all eight digits show 9; 100_000_000 -> "Err", overflow=1;
//    -9_999_999 -> minus in digit7; -10_000_000 and -2**31 -> "Err".
//  5 second load pulses at accept+1 and accept+27, plus a load on the done edge ->
//    all ignored, exactly one done, display = first value.
//  6 back-to-back: load value=-42 one edge after done -> new frame with minus in digit2;
//    overflow from an earlier "Err" clears at that accept.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the calculator HEX display: segment codes, FSM states,
// display range limits and the single-digit 7-seg encoder.
package hex_display_pkg;

  localparam int N_DIGITS    = 8;
  localparam int N_CONV_BITS = 27;

  localparam logic [31:0] MAX_POS = 32'd99_999_999;
  localparam logic [31:0] MAX_NEG = 32'd9_999_999;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FMT  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Load/result bus between the calculator datapath and the HEX display controller.
// Single-shot request: load is only honoured while busy is low.
interface hex_display_ctrl_if #(parameter int DIGITS = 8);
  logic                  load;
  logic [31:0]           value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   hex_seg;

  modport master (output load, output value,
                  input busy, input done, input overflow, input hex_seg);
  modport slave  (input load, input value,
                  output busy, output done, output overflow, output hex_seg);
endinterface

// File: rtl/hex_display_ctrl_bin2bcd_step.sv
// One shift-and-add-3 step over a packed BCD vector; purely combinational.
// No flow control: the caller decides when to register the result.
module bin2bcd_step #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                msb_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
    end
  end

  // The carry out of the top nibble only occurs for undisplayable values.
  assign bcd_out = (4*DIGITS)'({adj, msb_in});

endmodule

// File: rtl/hex_display_ctrl.sv
// Signed 32-bit to eight-digit 7-seg driver: sequential BCD conversion, blanking, sign, "Err".
// Latency CONV_BITS+1 edges after accept; loads while busy are dropped, never queued.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = N_DIGITS,
  parameter int CONV_BITS = N_CONV_BITS
) (
  input logic              clk1,
  input logic              reset_n,
  hex_display_ctrl_if.slave bus
);

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [CONV_BITS-1:0]  mag_q, mag_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d, bcd_step;
  logic                  neg_q, neg_d;
  logic                  range_ovf_q, range_ovf_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d, frame;
  logic [31:0]           abs_val;
  logic                  accept, last_step, busy;
  int                    ms;

  bin2bcd_step #(.DIGITS(DIGITS)) u_step (
    .bcd_in  (bcd_q),
    .msb_in  (mag_q[CONV_BITS-1]),
    .bcd_out (bcd_step)
  );

  always_ff @(posedge clk1) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.load) state_d = ST_CONV;
      ST_CONV: if (last_step) state_d = ST_FMT;
      ST_FMT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    accept    = (state_q == ST_IDLE) && bus.load;
    last_step = (state_q == ST_CONV) && (cnt_q == 5'(CONV_BITS-1));
  end

  assign abs_val = bus.value[31] ? (~bus.value + 32'd1) : bus.value;

  always_comb begin
    ms = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ms = i;
    end
    frame = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (range_ovf_q) begin
        frame[7*i +: 7] = (i == 2) ? SEG_E : (i < 2) ? SEG_R : SEG_BLANK;
      end else if (i <= ms) begin
        frame[7*i +: 7] = seg_encode(bcd_q[4*i +: 4]);
      end else if (neg_q && (i == ms + 1)) begin
        frame[7*i +: 7] = SEG_MINUS;
      end else begin
        frame[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    range_ovf_d = range_ovf_q;
    ovf_d       = ovf_q;
    seg_d       = seg_q;
    done_d      = (state_q == ST_FMT);
    if (accept) begin
      neg_d       = bus.value[31];
      mag_d       = abs_val[CONV_BITS-1:0];
      bcd_d       = '0;
      cnt_d       = 5'd0;
      range_ovf_d = bus.value[31] ? (abs_val > MAX_NEG) : (abs_val > MAX_POS);
      ovf_d       = 1'b0;
    end
    if (state_q == ST_CONV) begin
      mag_d = {mag_q[CONV_BITS-2:0], 1'b0};
      bcd_d = bcd_step;
      cnt_d = cnt_q + 5'd1;
    end
    if (state_q == ST_FMT) begin
      seg_d = frame;
      ovf_d = range_ovf_q;
    end
  end

  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      cnt_q       <= 5'd0;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      range_ovf_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      seg_q       <= '1;
    end else begin
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      range_ovf_q <= range_ovf_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex_seg  = seg_q;

endmodule
